// File: rtl/handshake_pkg.sv
// Shared definitions for the four-phase Request/Ack word link (transmitter and receiver).
package handshake_pkg;

    localparam int DEFAULT_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_REQ   = 2'd2,
        ST_REL   = 2'd3
    } hs_state_t;

endpackage

// File: rtl/tx_fifo.sv
// Synchronous FIFO, 2**DEPTH_LOG2 entries, head visible combinationally on data_o.
// Pointers wrap modulo depth; count is one bit wider so full and empty are distinct.
module tx_fifo
    import handshake_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_W-1:0]     data_i,
    output logic [DATA_W-1:0]     data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: it is only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/transmitter.sv
// Sending end of the four-phase Request/Ack handshake, fed from a small word FIFO.
// Define TX_ACK_SYNC_EN to pass Ack through a two-flop synchronizer (adds 2 cycles per Ack edge).
module transmitter
    import handshake_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              Load,
    input  logic [DATA_W-1:0] txDataIn,
    output logic              Full,
    output logic              Overflow,
    output logic              Idle,
    output logic              Request,
    input  logic              Ack,
    output logic [DATA_W-1:0] txDataOut
);

    hs_state_t             state_q, state_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  request_q, request_d;
    logic                  overflow_q, overflow_d;
    logic                  ack_s;
    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_W-1:0]     fifo_head;
    logic [DEPTH_LOG2:0]   fifo_count;

`ifdef TX_ACK_SYNC_EN
    logic [1:0] ack_sync_q;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) ack_sync_q <= 2'b00;
        else       ack_sync_q <= {ack_sync_q[0], Ack};
    end

    assign ack_s = ack_sync_q[1];
`else
    assign ack_s = Ack;
`endif

    // Full is the pre-edge count, so a Load while full is dropped even if a pop happens now.
    assign fifo_push = Load && !fifo_full;

    tx_fifo #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rst     (Reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .data_i  (txDataIn),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    data_d   = fifo_head;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (!ack_s) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (ack_s) state_d = ST_REL;
            end
            ST_REL: begin
                if (!ack_s) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        data_d   = fifo_head;
                        state_d  = ST_SETUP;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        request_d  = (state_d == ST_REQ);
        overflow_d = overflow_q || (Load && fifo_full);
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            request_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            request_q  <= request_d;
            overflow_q <= overflow_d;
        end
    end

    assign Request   = request_q;
    assign txDataOut = data_q;
    assign Overflow  = overflow_q;
    assign Full      = fifo_full;
    assign Idle      = (state_q == ST_IDLE) && (fifo_count == '0);

endmodule
